icache: RTL and testbench

- Direct-mapped, read-only instruction cache. Sits between the instruction fetcher and the memory controller on the fetch path.
- Hits return the 32-bit instruction word one cycle after the request is accepted. Misses issue a single word read to the memory controller, fill the line, then respond.
- A mispredict flush cancels the pending response but never aborts an outstanding memory read.

---
 rtl/icache.sv | 162 ++++++++++++++++
 tb/tb_icache.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 256 one-word lines.
// A hit answers one cycle after the request is accepted. A miss issues a
// single word read to the memory controller, fills the line, then answers.
// A flush cancels the pending response but never aborts an outstanding read.
module icache #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_USED   = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_ins,
  input  logic        flush,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_ok,
  input  logic [31:0] mem_ins,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_USED - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MISS    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Line storage. Only the valid bits are cleared by reset; tag and data
  // are meaningless while their valid bit is low.
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TAG_W-1:0]       fill_tag;

  logic        lookup_hit_p0;
  logic        accept_p0;
  logic        hit_p0;
  logic        miss_p0;
  logic        fill_p0;
  logic        resp_fill_p0;

  logic        resp_valid_p1;
  logic [31:0] resp_ins_p1;
  logic        mem_enable_q;
  logic [31:0] mem_addr_q;
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Byte-offset bits of the fetch PC carry no information for a word cache.
  logic [1:0] unused_addr_bits;
  assign unused_addr_bits = req_addr[1:0];

  // The latched miss address supplies the fill index and tag, so the
  // fetcher is free to change req_addr while the read is outstanding.
  assign req_idx  = req_addr[INDEX_WIDTH+1:2];
  assign req_tag  = req_addr[ADDR_USED-1:INDEX_WIDTH+2];
  assign fill_idx = mem_addr_q[INDEX_WIDTH+1:2];
  assign fill_tag = mem_addr_q[ADDR_USED-1:INDEX_WIDTH+2];

  // ---- stage p0: lookup and request/fill decode ----
  assign lookup_hit_p0 = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept_p0     = req_valid && req_ready;
  assign hit_p0        = accept_p0 && lookup_hit_p0;
  assign miss_p0       = accept_p0 && !lookup_hit_p0;
  // A mem_ok seen in IDLE belongs to a read cancelled by reset; ignore it.
  assign fill_p0       = mem_ok && (state_q != IDLE);
  assign resp_fill_p0  = mem_ok && (state_q == MISS) && !flush;

  // State register; reset wins over the global stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a flush while waiting turns the read into a discard.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_p0) state_d = MISS;
      MISS: begin
        if (mem_ok)     state_d = IDLE;
        else if (flush) state_d = DISCARD;
      end
      DISCARD: if (mem_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake from state, and a same-cycle flush squashes any
  // registered response.
  always_comb begin
    req_ready  = (state_q == IDLE) && !flush && !rst;
    resp_valid = resp_valid_p1 && !flush;
    resp_ins   = resp_ins_p1;
    mem_enable = mem_enable_q;
    mem_addr   = mem_addr_q;
    hit_count  = hit_count_q;
    miss_count = miss_count_q;
  end

  // ---- stage p1: response, memory request and statistics registers ----
  // Control and statistics registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      resp_valid_p1 <= 1'b0;
      resp_ins_p1   <= 32'd0;
      mem_enable_q  <= 1'b0;
      mem_addr_q    <= 32'd0;
      hit_count_q   <= 32'd0;
      miss_count_q  <= 32'd0;
    end else if (rdy) begin
      resp_valid_p1 <= hit_p0 || resp_fill_p0;
      if (hit_p0) begin
        resp_ins_p1 <= data_mem[req_idx];
      end else if (resp_fill_p0) begin
        resp_ins_p1 <= mem_ins;
      end
      if (miss_p0) begin
        mem_enable_q <= 1'b1;
        mem_addr_q   <= {req_addr[31:2], 2'b00};
      end else if (fill_p0) begin
        mem_enable_q <= 1'b0;
      end
      if (fill_p0) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (hit_p0) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_p0) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  // Line fill: a miss overwrites its index unconditionally.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_p0) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_ins;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: hand-computed expectations checked with
// immediate assertions after each step.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_ins;
  logic        flush;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic        mem_ok;
  logic [31:0] mem_ins;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int passed = 0;
  int total  = 0;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ins   (resp_ins),
    .flush      (flush),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_ok     (mem_ok),
    .mem_ins    (mem_ins),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Miss on addr; memory answers with word after lat cycles of mem_enable.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] word, input int lat);
    req_addr  = addr;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("miss_mem_enable", mem_enable, 1);
    chk("miss_mem_addr", mem_addr, exp_addr);
    chk("miss_no_resp", resp_valid, 0);
    chk("miss_not_ready", req_ready, 0);
    for (int i = 1; i < lat; i++) begin
      cycle();
      chk("miss_wait_enable", mem_enable, 1);
    end
    mem_ok  = 1'b1;
    mem_ins = word;
    cycle();
    mem_ok = 1'b0;
    chk("fill_enable_low", mem_enable, 0);
    chk("fill_resp_valid", resp_valid, 1);
    chk("fill_resp_ins", resp_ins, word);
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] word);
    req_addr  = addr;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("hit_resp_valid", resp_valid, 1);
    chk("hit_resp_ins", resp_ins, word);
    chk("hit_no_mem", mem_enable, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_addr = 32'd0;
    flush = 1'b0; mem_ok = 1'b0; mem_ins = 32'd0;
    cycle();
    cycle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ins", resp_ins, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);

    // Cold miss with a three-cycle memory.
    do_miss(32'h0, 32'h0, 32'h0000_0013, 3);
    chk("cold_miss_count", miss_count, 1);
    cycle();
    chk("cold_resp_pulse_ends", resp_valid, 0);

    // Hit, then four more back-to-back hits.
    do_hit(32'h0, 32'h0000_0013);
    chk("first_hit_count", hit_count, 1);
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("b2b_resp_valid", resp_valid, 1);
      chk("b2b_hit_count", hit_count, 32'(2 + i));
    end
    req_valid = 1'b0;
    cycle();
    chk("b2b_end_resp", resp_valid, 0);
    chk("b2b_final_hits", hit_count, 5);

    // Fresh counters for the conflict test.
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Conflict on index 1: 0x4 (tag 0) and 0x404 (tag 1); low bits ignored.
    do_miss(32'h0000_0004, 32'h0000_0004, 32'hAAAA_0001, 2);
    do_miss(32'h0000_0407, 32'h0000_0404, 32'hBBBB_0002, 1);
    do_hit(32'h0000_0404, 32'hBBBB_0002);
    do_miss(32'h0000_0004, 32'h0000_0004, 32'hAAAA_0001, 1);
    chk("conflict_misses", miss_count, 3);
    chk("conflict_hits", hit_count, 1);
    // Bit 18 lies above ADDR_USED, so 0x40004 aliases 0x4.
    do_hit(32'h0004_0004, 32'hAAAA_0001);
    chk("alias_hits", hit_count, 2);

    // Flush one cycle after a miss is issued; memory answers two cycles later.
    req_addr  = 32'h0000_0008;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_miss_not_ready", req_ready, 0);
    cycle();
    flush = 1'b0;
    #1;
    chk("discard_enable", mem_enable, 1);
    chk("discard_not_ready", req_ready, 0);
    cycle();
    chk("discard_enable_hold", mem_enable, 1);
    chk("discard_no_resp", resp_valid, 0);
    mem_ok  = 1'b1;
    mem_ins = 32'hCCCC_0003;
    cycle();
    mem_ok = 1'b0;
    #1;
    chk("discard_done_no_resp", resp_valid, 0);
    chk("discard_done_enable", mem_enable, 0);
    chk("discard_done_ready", req_ready, 1);
    do_hit(32'h0000_0008, 32'hCCCC_0003);

    // Flush coinciding with mem_ok: line filled, no response.
    req_addr  = 32'h0000_000C;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("flushok_enable", mem_enable, 1);
    mem_ok  = 1'b1;
    mem_ins = 32'hDDDD_0004;
    flush   = 1'b1;
    cycle();
    mem_ok = 1'b0;
    flush  = 1'b0;
    #1;
    chk("flushok_no_resp", resp_valid, 0);
    chk("flushok_enable_low", mem_enable, 0);
    chk("flushok_ready", req_ready, 1);
    do_hit(32'h0000_000C, 32'hDDDD_0004);

    // Flush the cycle after a hit is accepted squashes the response.
    req_addr  = 32'h0000_000C;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("hitflush_squash", resp_valid, 0);
    chk("hitflush_hits", hit_count, 5);
    cycle();
    flush = 1'b0;
    #1;
    chk("hitflush_after", resp_valid, 0);

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1;
    flush = 1'b1;
    cycle();
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("idleflush_no_resp", resp_valid, 0);
    chk("idleflush_hits", hit_count, 5);

    // Stall for five cycles in MISS with a mem_ok pulse that must be ignored.
    req_addr  = 32'h0000_0010;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("stall_miss_enable", mem_enable, 1);
    chk("stall_miss_count", miss_count, 6);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ok  = (i == 2);
      mem_ins = 32'h1234_5678;
      cycle();
      chk("stall_enable", mem_enable, 1);
      chk("stall_no_resp", resp_valid, 0);
      chk("stall_not_ready", req_ready, 0);
    end
    mem_ok = 1'b0;
    rdy = 1'b1;
    cycle();
    chk("stall_still_waiting", mem_enable, 1);
    chk("stall_still_no_resp", resp_valid, 0);
    mem_ok  = 1'b1;
    mem_ins = 32'hEEEE_0005;
    cycle();
    mem_ok = 1'b0;
    chk("stall_fill_resp", resp_valid, 1);
    chk("stall_fill_ins", resp_ins, 32'hEEEE_0005);
    chk("stall_fill_enable", mem_enable, 0);
    do_hit(32'h0000_0010, 32'hEEEE_0005);

    // Reset in the middle of a miss; a late mem_ok is ignored.
    req_addr  = 32'h0000_0014;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("rstmiss_enable", mem_enable, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstmiss_enable_low", mem_enable, 0);
    chk("rstmiss_addr", mem_addr, 0);
    chk("rstmiss_hits", hit_count, 0);
    chk("rstmiss_misses", miss_count, 0);
    chk("rstmiss_resp", resp_valid, 0);
    mem_ok  = 1'b1;
    mem_ins = 32'hFFFF_0006;
    cycle();
    mem_ok = 1'b0;
    chk("late_ok_no_resp", resp_valid, 0);
    chk("late_ok_no_enable", mem_enable, 0);
    // Valid bits were cleared and the late word was not written.
    do_miss(32'h0000_0010, 32'h0000_0010, 32'hEEEE_0007, 1);
    do_miss(32'h0000_0014, 32'h0000_0014, 32'h5555_0008, 1);
    chk("post_rst_misses", miss_count, 2);
    chk("post_rst_hits", hit_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
